midi_voice_alloc: RTL and testbench



---
 rtl/midi_voice_alloc.sv | 140 ++++++++++++++
 tb/tb_midi_voice_alloc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: polyphonic MIDI voice allocator (retrigger, free-first, oldest-steal).
// Define SUSTAIN_PEDAL_EN to honour CC 64 sustain pedal.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_BITS = 4,
  parameter int CHANNEL = 0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic event_valid,
  input  logic [23:0] midi_event,
  output logic [NUM_VOICES-1:0] voice_gate,
  output logic [NUM_VOICES-1:0] voice_trigger,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic steal_pulse
);
  localparam int N = NUM_VOICES;
  localparam int A = AGE_BITS;
  localparam int IW = $clog2(N);
  logic [N-1:0] gate_q, gate_d, trig_q, trig_d;
  logic [7*N-1:0] note_q, note_d, vel_q, vel_d;
  logic [A*N-1:0] age_q, age_d;
  logic steal_q, steal_d;
  logic [3:0] kind;
  logic [6:0] d1, d2;
  logic ch_ok, note_on, note_off, hit, free;
  logic [IW-1:0] hit_idx, free_idx, old_idx, tgt;
  logic [A-1:0] old_age;
  logic unused_bits;
  assign kind = midi_event[23:20];
  assign d1 = midi_event[14:8];
  assign d2 = midi_event[6:0];
  assign unused_bits = midi_event[15] ^ midi_event[7];
  assign ch_ok = event_valid && midi_event[19:16] == 4'(CHANNEL);
  assign note_on = ch_ok && kind == 4'h9 && d2 != 7'd0;
  assign note_off = ch_ok && (kind == 4'h8 || (kind == 4'h9 && d2 == 7'd0));
`ifdef SUSTAIN_PEDAL_EN
  logic [N-1:0] sus_q, sus_d;
  logic pedal_q, pedal_d, cc64;
  assign cc64 = ch_ok && kind == 4'hB && d1 == 7'd64;
`endif
  // Strict '>' keeps the lowest index on equal ages.
  always_comb begin
    hit = 1'b0;
    free = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    old_idx = '0;
    old_age = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && gate_q[i] && note_q[7*i +: 7] == d1) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!free && !gate_q[i]) begin
        free = 1'b1;
        free_idx = IW'(i);
      end
      if (age_q[A*i +: A] > old_age) begin
        old_age = age_q[A*i +: A];
        old_idx = IW'(i);
      end
    end
    tgt = hit ? hit_idx : free ? free_idx : old_idx;
  end
  always_comb begin
    gate_d = gate_q;
    note_d = note_q;
    vel_d = vel_q;
    age_d = age_q;
    trig_d = '0;
    steal_d = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
    sus_d = sus_q;
    pedal_d = pedal_q;
`endif
    if (note_on) begin
      for (int i = 0; i < N; i++)
        if (gate_q[i] && age_q[A*i +: A] != {A{1'b1}}) age_d[A*i +: A] = age_q[A*i +: A] + 1'b1;
      age_d[A*tgt +: A] = '0;
      note_d[7*tgt +: 7] = d1;
      vel_d[7*tgt +: 7] = d2;
      gate_d[tgt] = 1'b1;
      trig_d[tgt] = 1'b1;
      steal_d = !hit && !free;
`ifdef SUSTAIN_PEDAL_EN
      sus_d[tgt] = 1'b0;
`endif
    end else if (note_off) begin
      for (int i = 0; i < N; i++)
        if (gate_q[i] && note_q[7*i +: 7] == d1)
`ifdef SUSTAIN_PEDAL_EN
          if (pedal_q) sus_d[i] = 1'b1;
          else gate_d[i] = 1'b0;
`else
          gate_d[i] = 1'b0;
`endif
    end
`ifdef SUSTAIN_PEDAL_EN
    else if (cc64) begin
      pedal_d = d2[6];
      if (!d2[6]) begin
        gate_d = gate_q & ~sus_q;
        sus_d = '0;
      end
    end
`endif
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gate_q <= '0;
      trig_q <= '0;
      note_q <= '0;
      vel_q <= '0;
      age_q <= '0;
      steal_q <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
      sus_q <= '0;
      pedal_q <= 1'b0;
`endif
    end else begin
      gate_q <= gate_d;
      trig_q <= trig_d;
      note_q <= note_d;
      vel_q <= vel_d;
      age_q <= age_d;
      steal_q <= steal_d;
`ifdef SUSTAIN_PEDAL_EN
      sus_q <= sus_d;
      pedal_q <= pedal_d;
`endif
    end
  end
  assign voice_gate = gate_q;
  assign voice_trigger = trig_q;
  assign voice_note = note_q;
  assign voice_velocity = vel_q;
  assign steal_pulse = steal_q;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc: scoreboard bench; a reference model queues expected outputs per driven cycle.
module tb_midi_voice_alloc;
  localparam int N = 4;
  localparam int AMAX = 15;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic event_valid = 1'b0;
  logic [23:0] midi_event = '0;
  logic [N-1:0] voice_gate, voice_trigger;
  logic [7*N-1:0] voice_note, voice_velocity;
  logic steal_pulse;
  midi_voice_alloc #(.NUM_VOICES(N), .AGE_BITS(4), .CHANNEL(0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .event_valid(event_valid), .midi_event(midi_event),
    .voice_gate(voice_gate), .voice_trigger(voice_trigger), .voice_note(voice_note),
    .voice_velocity(voice_velocity), .steal_pulse(steal_pulse)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic [N-1:0] gate;
    logic [N-1:0] trig;
    logic [7*N-1:0] note;
    logic [7*N-1:0] vel;
    logic steal;
  } snap_t;
  snap_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int step = 0;
  bit m_gate[N];
  bit m_sus[N];
  bit m_pedal;
  logic [6:0] m_note[N];
  logic [6:0] m_vel[N];
  int m_age[N];
  logic [N-1:0] e_trig;
  bit e_steal;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input bit rst, input bit v, input logic [23:0] ev);
    logic [3:0] typ;
    logic [6:0] n, d;
    int t;
    e_trig = '0;
    e_steal = 0;
    if (rst) begin
      m_pedal = 0;
      for (int i = 0; i < N; i++) begin
        m_gate[i] = 0; m_sus[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      end
    end else if (v && ev[19:16] == 4'h0) begin
      typ = ev[23:20];
      n = ev[14:8];
      d = ev[6:0];
      if (typ == 4'h9 && d != 0) begin
        t = -1;
        for (int i = 0; i < N; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
        for (int i = 0; i < N; i++) if (t < 0 && !m_gate[i]) t = i;
        if (t < 0) begin
          t = 0;
          for (int i = 1; i < N; i++) if (m_age[i] > m_age[t]) t = i;
          e_steal = 1;
        end
        for (int i = 0; i < N; i++) if (i != t && m_gate[i] && m_age[i] < AMAX) m_age[i]++;
        m_gate[t] = 1; m_note[t] = n; m_vel[t] = d; m_age[t] = 0; m_sus[t] = 0;
        e_trig[t] = 1'b1;
      end else if (typ == 4'h8 || typ == 4'h9) begin
        for (int i = 0; i < N; i++)
          if (m_gate[i] && m_note[i] == n) begin
`ifdef SUSTAIN_PEDAL_EN
            if (m_pedal) m_sus[i] = 1;
            else m_gate[i] = 0;
`else
            m_gate[i] = 0;
`endif
          end
      end
`ifdef SUSTAIN_PEDAL_EN
      else if (typ == 4'hB && n == 7'd64) begin
        m_pedal = d >= 64;
        if (!m_pedal)
          for (int i = 0; i < N; i++) if (m_sus[i]) begin m_gate[i] = 0; m_sus[i] = 0; end
      end
`endif
    end
  endtask
  task automatic compare_front();
    snap_t s;
    if (sb.size() > 0) begin
      s = sb.pop_front();
      check($sformatf("gate@%0d", step), 64'(voice_gate), 64'(s.gate));
      check($sformatf("trig@%0d", step), 64'(voice_trigger), 64'(s.trig));
      check($sformatf("note@%0d", step), 64'(voice_note), 64'(s.note));
      check($sformatf("vel@%0d", step), 64'(voice_velocity), 64'(s.vel));
      check($sformatf("steal@%0d", step), 64'(steal_pulse), 64'(s.steal));
    end
  endtask
  task automatic apply(input bit rst, input bit v, input logic [23:0] ev);
    snap_t s;
    @(negedge clk_in);
    compare_front();
    step++;
    rst_in = rst;
    event_valid = v;
    midi_event = ev;
    model(rst, v, ev);
    for (int i = 0; i < N; i++) begin
      s.gate[i] = m_gate[i];
      s.note[7*i +: 7] = m_note[i];
      s.vel[7*i +: 7] = m_vel[i];
    end
    s.trig = e_trig;
    s.steal = e_steal;
    sb.push_back(s);
  endtask
  task automatic ev(input logic [7:0] st, input logic [7:0] a, input logic [7:0] b);
    apply(0, 1, {st, a, b});
  endtask
  task automatic idle();
    apply(0, 0, 24'h90_3C_40);
  endtask
  task automatic rst();
    apply(1, 0, 24'h0);
  endtask
  initial begin
    rst();
    idle();
    ev(8'h90, 8'd75, 8'd100);
    idle();
    idle();
    rst();
    ev(8'h90, 8'd60, 8'd10);
    ev(8'h90, 8'd62, 8'd20);
    ev(8'h90, 8'd64, 8'd30);
    ev(8'h90, 8'd65, 8'd40);
    ev(8'h90, 8'd67, 8'd50);
    idle();
    rst();
    ev(8'h90, 8'd70, 8'd90);
    ev(8'h80, 8'd70, 8'd0);
    idle();
    ev(8'h80, 8'd71, 8'd0);
    ev(8'h90, 8'd72, 8'd0);
    ev(8'h90, 8'd72, 8'd33);
    ev(8'h90, 8'd72, 8'd44);
    ev(8'h90, 8'hC8, 8'hD5);
    ev(8'h90, 8'd72, 8'd0);
    ev(8'h91, 8'd50, 8'd60);
    ev(8'hE0, 8'd10, 8'd20);
    ev(8'hB0, 8'd64, 8'd127);
    ev(8'hB0, 8'd64, 8'd0);
    idle();
    apply(1, 1, 24'h90_30_40);
    idle();
    ev(8'h90, 8'd10, 8'd1);
    ev(8'h90, 8'd11, 8'd2);
    ev(8'h90, 8'd12, 8'd3);
    ev(8'h90, 8'd13, 8'd4);
    for (int i = 0; i < 13; i++) ev(8'h90, 8'd13, 8'(5 + i));
    ev(8'h90, 8'd14, 8'd99);
    ev(8'h90, 8'd15, 8'd98);
`ifdef SUSTAIN_PEDAL_EN
    rst();
    ev(8'hB0, 8'd64, 8'd127);
    ev(8'h90, 8'd50, 8'd80);
    ev(8'h80, 8'd50, 8'd0);
    idle();
    ev(8'h90, 8'd52, 8'd81);
    ev(8'hB0, 8'd64, 8'd63);
    idle();
`endif
    rst();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] st, a, b;
      int r;
      r = $urandom_range(0, 9);
      st = r < 5 ? 8'h90 : r < 8 ? 8'h80 : r == 8 ? 8'hB0 : 8'h91;
      a = (st == 8'hB0) ? 8'd64 : 8'(60 + $urandom_range(0, 5)) | (8'($urandom_range(0, 1)) << 7);
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      if ($urandom_range(0, 9) == 0) idle();
      else ev(st, a, b);
    end
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
